// File: rtl/id_stage.sv
// Decode stage: IF/ID register, MIPS-subset decode, 32x32 regfile with write-back bypass; decode is combinational off IF/ID.
// Backpressure: Stall or LoadUse holds IF/ID (LoadUse also bubbles controls toward EX); Flush overrides both.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Inst_in,
    input  logic [31:0] PC_in,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RegWr_wb,
    input  logic [4:0]  Rw_wb,
    input  logic [31:0] busW_wb,
    input  logic        ex_MemtoReg,
    input  logic [4:0]  ex_Rw,
    output logic        Valid,
    output logic [31:0] PC,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] imm16,
    output logic [25:0] target,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic        Jump,
    output logic        Branch,
    output logic        ExtOp,
    output logic        RegWr,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemWr,
    output logic        MemtoReg,
    output logic [2:0]  ALUctr,
    output logic        LoadUse,
    output logic        Illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       ext_op;
        logic       reg_wr;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_wr;
        logic       memto_reg;
        logic [2:0] alu_ctr;
    } ctrl_t;

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    ctrl_t       dec_ctrl, out_ctrl;
    logic        dec_legal, live, rt_src, load_use;

    assign op     = inst_q[31:26];
    assign funct  = inst_q[5:0];
    assign Rs     = inst_q[25:21];
    assign Rt     = inst_q[20:16];
    assign Rd     = inst_q[15:11];
    assign imm16  = inst_q[15:0];
    assign target = inst_q[25:0];
    assign Valid  = valid_q;
    assign PC     = pc_q;

    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.reg_dst = 1'b1;
                case (funct)
                    FN_ADDU: dec_ctrl.alu_ctr = 3'b000;
                    FN_SUBU: dec_ctrl.alu_ctr = 3'b001;
                    FN_SLT:  dec_ctrl.alu_ctr = 3'b010;
                    default: begin
                        dec_ctrl  = '0;
                        dec_legal = 1'b0;
                    end
                endcase
            end
            OP_ORI: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.alu_ctr = 3'b011;
            end
            OP_ADDIU: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.ext_op  = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.reg_wr    = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.memto_reg = 1'b1;
                dec_ctrl.ext_op    = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.mem_wr  = 1'b1;
                dec_ctrl.ext_op  = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl.branch  = 1'b1;
                dec_ctrl.alu_ctr = 3'b001;
                dec_ctrl.ext_op  = 1'b1;
            end
            OP_J:    dec_ctrl.jump = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // An all-zero word is the flush bubble, not an illegal instruction.
    assign live     = valid_q && (inst_q != 32'h0);
    assign rt_src   = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    assign load_use = valid_q && ex_MemtoReg && (ex_Rw != 5'd0) &&
                      ((ex_Rw == Rs) || ((ex_Rw == Rt) && rt_src));
    assign LoadUse  = load_use;
    assign Illegal  = live && !dec_legal;
    assign out_ctrl = (live && dec_legal && !load_use) ? dec_ctrl : '0;

    assign Jump     = out_ctrl.jump;
    assign Branch   = out_ctrl.branch;
    assign ExtOp    = out_ctrl.ext_op;
    assign RegWr    = out_ctrl.reg_wr;
    assign RegDst   = out_ctrl.reg_dst;
    assign ALUSrc   = out_ctrl.alu_src;
    assign MemWr    = out_ctrl.mem_wr;
    assign MemtoReg = out_ctrl.memto_reg;
    assign ALUctr   = out_ctrl.alu_ctr;

    always_comb begin
        busA = rf_q[Rs];
        busB = rf_q[Rt];
        if (BYPASS && RegWr_wb && (Rw_wb != 5'd0)) begin
            if (Rw_wb == Rs) busA = busW_wb;
            if (Rw_wb == Rt) busB = busW_wb;
        end
        if (Rs == 5'd0) busA = '0;
        if (Rt == 5'd0) busB = '0;
    end

    always_comb begin
        inst_d  = Inst_in;
        pc_d    = PC_in;
        valid_d = 1'b1;
        if (Flush) begin
            inst_d  = '0;
            pc_d    = RESET_PC;
            valid_d = 1'b0;
        end else if (Stall || load_use) begin
            inst_d  = inst_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            inst_q  <= '0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (RegWr_wb && (Rw_wb != 5'd0)) begin
            rf_q[Rw_wb] <= busW_wb;
        end
    end

endmodule
